// File: rtl/linreg_pkg.sv
// Shared types and helpers for the streaming line fitter: FSM states,
// derived width functions and result saturation.
package linreg_pkg;

    typedef enum logic [2:0] {
        ACCUM,
        PREP,
        DIV_S,
        DIV_I,
        DONE
    } state_t;

    localparam int unsigned SAT_IN_W  = 128;
    localparam int unsigned SAT_OUT_W = 64;

    typedef struct packed {
        logic                        sat;
        logic signed [SAT_OUT_W-1:0] val;
    } sat_t;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ms);
        return 2 * dw + $clog2(ms + 1);
    endfunction

    function automatic int unsigned num_width(input int unsigned aw);
        return 2 * aw + 2;
    endfunction

    // Clamp a wide signed value into the rw-bit signed range.
    function automatic sat_t sat_to_result(input logic signed [SAT_IN_W-1:0] v,
                                           input int unsigned rw);
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        sat_t r;
        hi    = (SAT_IN_W'(1) << (rw - 1)) - SAT_IN_W'(1);
        lo    = -hi - SAT_IN_W'(1);
        r.sat = 1'b0;
        r.val = SAT_OUT_W'(v);
        if (v > hi) begin
            r.sat = 1'b1;
            r.val = SAT_OUT_W'(hi);
        end else if (v < lo) begin
            r.sat = 1'b1;
            r.val = SAT_OUT_W'(lo);
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_linreg_seq_divider.sv
// Sequential signed divider: magnitude restoring division, one quotient bit
// per cycle, W cycles per operation, quotient truncated toward zero.
module seq_divider
    import linreg_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter bit          ROUND = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] dividend,
    input  logic signed [W-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic signed [W:0]   quotient
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  dq;
    logic [W-1:0]  b;
    logic [W-1:0]  rem;
    logic          neg;
    logic [CW-1:0] cnt;

    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W:0]    rem_sh;
    logic [W:0]    rem_n;
    logic          ge;
    logic [W-1:0]  dq_n;

    always_comb begin
        b_mag = divisor[W-1] ? $unsigned(-divisor) : $unsigned(divisor);
        a_mag = dividend[W-1] ? $unsigned(-dividend) : $unsigned(dividend);
        // Biasing the magnitude by half the divisor gives round-half-away-from-zero.
        if (ROUND) begin
            a_mag = a_mag + (b_mag >> 1);
        end
        rem_sh = {rem, dq[W-1]};
        ge     = (rem_sh >= {1'b0, b});
        rem_n  = ge ? (rem_sh - {1'b0, b}) : rem_sh;
        dq_n   = {dq[W-2:0], ge};
    end

    assign done = busy && (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            dq       <= '0;
            b        <= '0;
            rem      <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            quotient <= '0;
        end else begin
            if (busy) begin
                dq  <= dq_n;
                rem <= W'(rem_n);
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy     <= 1'b0;
                    quotient <= neg ? -$signed({1'b0, dq_n}) : $signed({1'b0, dq_n});
                end
            end
            // A new start may coincide with the final step of the previous one.
            if (start) begin
                dq   <= a_mag;
                b    <= b_mag;
                rem  <= '0;
                neg  <= dividend[W-1] ^ divisor[W-1];
                cnt  <= CW'(W);
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_linreg.sv
// Streaming least-squares line fitter: accumulates sample sums, forms the
// normal equations and divides by det. `LINREG_ROUND_EN selects rounded quotients.
module stream_linreg
    import linreg_pkg::*;
#(
    parameter int DATA_WIDTH   = 14,
    parameter int MAX_SAMPLES  = 8,
    parameter int RESULT_WIDTH = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH-1:0]   x_in,
    input  logic signed [DATA_WIDTH-1:0]   y_in,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [RESULT_WIDTH-1:0] slope,
    output logic signed [RESULT_WIDTH-1:0] intercept,
    output logic signed [RESULT_WIDTH-1:0] det,
    output logic                           err_singular,
    output logic                           err_sat,
    output logic                           err_trunc,
    output logic                           busy
);

    localparam int unsigned ACC_W = acc_width(DATA_WIDTH, MAX_SAMPLES);
    localparam int unsigned NUM_W = num_width(ACC_W);
    localparam int unsigned CNT_W = $clog2(MAX_SAMPLES + 1);
`ifdef LINREG_ROUND_EN
    localparam int unsigned DIV_W     = NUM_W + 1;
    localparam bit          DIV_ROUND = 1'b1;
`else
    localparam int unsigned DIV_W     = NUM_W;
    localparam bit          DIV_ROUND = 1'b0;
`endif

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc_sx, acc_sy, acc_sxx, acc_sxy;
    logic signed [ACC_W-1:0] x_e, y_e;
    logic signed [NUM_W-1:0] n_w, sx_w, sy_w, sxx_w, sxy_w;
    logic signed [NUM_W-1:0] det_c, num_s_c, num_i_c;
    logic signed [NUM_W-1:0] det_r, num_i_r;
    logic                    div_start, div_busy, div_done;
    logic signed [DIV_W-1:0] div_num, div_den;
    logic signed [DIV_W:0]   div_q, q_s_r;
    sat_t                    sat_s, sat_i, sat_d;

    assign x_e     = ACC_W'(x_in);
    assign y_e     = ACC_W'(y_in);
    assign n_w     = NUM_W'(cnt);
    assign sx_w    = NUM_W'(acc_sx);
    assign sy_w    = NUM_W'(acc_sy);
    assign sxx_w   = NUM_W'(acc_sxx);
    assign sxy_w   = NUM_W'(acc_sxy);
    assign det_c   = n_w * sxx_w - sx_w * sx_w;
    assign num_s_c = n_w * sxy_w - sx_w * sy_w;
    assign num_i_c = sy_w * sxx_w - sx_w * sxy_w;

    assign sat_s = sat_to_result(SAT_IN_W'(q_s_r), RESULT_WIDTH);
    assign sat_i = sat_to_result(SAT_IN_W'(div_q), RESULT_WIDTH);
    assign sat_d = sat_to_result(SAT_IN_W'(det_r), RESULT_WIDTH);

    // The slope division is launched straight from PREP using the live products,
    // so DIV_S spends all of its cycles iterating.
    always_comb begin
        div_start = 1'b0;
        div_num   = DIV_W'(num_s_c);
        div_den   = DIV_W'(det_c);
        if (state == PREP) begin
            div_start = (det_c != '0);
        end else if (state == DIV_S && div_busy && div_done) begin
            div_start = 1'b1;
            div_num   = DIV_W'(num_i_r);
            div_den   = DIV_W'(det_r);
        end
    end

    seq_divider #(
        .W     (DIV_W),
        .ROUND (DIV_ROUND)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (div_den),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            cnt          <= '0;
            acc_sx       <= '0;
            acc_sy       <= '0;
            acc_sxx      <= '0;
            acc_sxy      <= '0;
            det_r        <= '0;
            num_i_r      <= '0;
            q_s_r        <= '0;
            out_valid    <= 1'b0;
            slope        <= '0;
            intercept    <= '0;
            det          <= '0;
            err_singular <= 1'b0;
            err_sat      <= 1'b0;
            err_trunc    <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc_sx  <= acc_sx + x_e;
                        acc_sy  <= acc_sy + y_e;
                        acc_sxx <= acc_sxx + x_e * x_e;
                        acc_sxy <= acc_sxy + x_e * y_e;
                        cnt     <= cnt + 1'b1;
                        if (in_last || cnt == CNT_W'(MAX_SAMPLES - 1)) begin
                            state     <= PREP;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                            err_trunc <= !in_last;
                        end
                    end
                end
                PREP: begin
                    det_r   <= det_c;
                    num_i_r <= num_i_c;
                    if (det_c == '0) begin
                        err_singular <= 1'b1;
                        state        <= DONE;
                    end else begin
                        state <= DIV_S;
                    end
                end
                DIV_S: begin
                    if (div_busy && div_done) begin
                        state <= DIV_I;
                    end
                end
                DIV_I: begin
                    // div_q still holds the slope quotient until this edge.
                    if (div_busy && div_done) begin
                        q_s_r <= div_q;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        det       <= RESULT_WIDTH'(sat_d.val);
                        if (err_singular) begin
                            slope     <= '0;
                            intercept <= '0;
                            err_sat   <= sat_d.sat;
                        end else begin
                            slope     <= RESULT_WIDTH'(sat_s.val);
                            intercept <= RESULT_WIDTH'(sat_i.val);
                            err_sat   <= sat_s.sat | sat_i.sat | sat_d.sat;
                        end
                    end else if (out_ready) begin
                        out_valid    <= 1'b0;
                        cnt          <= '0;
                        acc_sx       <= '0;
                        acc_sy       <= '0;
                        acc_sxx      <= '0;
                        acc_sxy      <= '0;
                        err_singular <= 1'b0;
                        err_sat      <= 1'b0;
                        err_trunc    <= 1'b0;
                        in_ready     <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_linreg.sv
// Self-checking bench for stream_linreg: directed vector table, hand-written
// truncation/reset sequences, and randomized sets checked against an arithmetic model.
module tb_stream_linreg;

    localparam int DW    = 14;
    localparam int MS    = 8;
    localparam int RW    = 14;
    localparam int NUM_W = 2 * (2 * DW + $clog2(MS + 1)) + 2;
`ifdef LINREG_ROUND_EN
    localparam int LAT = 2 * (NUM_W + 1) + 2;
    localparam int SL4 = 1;
`else
    localparam int LAT = 2 * NUM_W + 2;
    localparam int SL4 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic signed [DW-1:0] x_in = '0;
    logic signed [DW-1:0] y_in = '0;
    logic in_ready, out_valid, err_singular, err_sat, err_trunc, busy;
    logic signed [RW-1:0] slope, intercept, det;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_linreg #(
        .DATA_WIDTH   (DW),
        .MAX_SAMPLES  (MS),
        .RESULT_WIDTH (RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x_in         (x_in),
        .y_in         (y_in),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .slope        (slope),
        .intercept    (intercept),
        .det          (det),
        .err_singular (err_singular),
        .err_sat      (err_sat),
        .err_trunc    (err_trunc),
        .busy         (busy)
    );

    typedef struct {
        int n;
        bit use_last;
        int slope;
        int icpt;
        int det;
        bit sing;
        bit sat;
        bit trunc;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl[NV];
    int   vx[NV][8];
    int   vy[NV][8];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic sat_val(input longint v, output int r, output bit s);
        longint hi, lo;
        hi = (longint'(1) << (RW - 1)) - 1;
        lo = -(longint'(1) << (RW - 1));
        s  = 1'b0;
        r  = int'(v);
        if (v > hi) begin r = int'(hi); s = 1'b1; end
        if (v < lo) begin r = int'(lo); s = 1'b1; end
    endtask

    function automatic longint qdiv(input longint n, input longint d);
`ifdef LINREG_ROUND_EN
        longint an, ad, q;
        an = (n < 0) ? -n : n;
        ad = (d < 0) ? -d : d;
        q  = (an + ad / 2) / ad;
        return ((n < 0) != (d < 0)) ? -q : q;
`else
        return n / d;
`endif
    endfunction

    // Least-squares reference computed directly from the sample sums.
    task automatic model(input int n, input int xs[8], input int ys[8], input bit ul,
                         output int es, output int ei, output int ed,
                         output bit sg, output bit st, output bit tr);
        longint sx, sy, sxx, sxy, d, ns, ni, qs, qi;
        bit s1, s2, s3;
        sx = 0; sy = 0; sxx = 0; sxy = 0;
        for (int i = 0; i < n; i++) begin
            sx  += xs[i];
            sy  += ys[i];
            sxx += longint'(xs[i]) * xs[i];
            sxy += longint'(xs[i]) * ys[i];
        end
        d  = n * sxx - sx * sx;
        ns = n * sxy - sx * sy;
        ni = sy * sxx - sx * sxy;
        tr = !ul && (n == MS);
        sg = (d == 0);
        qs = sg ? 0 : qdiv(ns, d);
        qi = sg ? 0 : qdiv(ni, d);
        sat_val(qs, es, s1);
        sat_val(qi, ei, s2);
        sat_val(d, ed, s3);
        st = s1 | s2 | s3;
    endtask

    task automatic send(input int x, input int y, input bit last, output int t);
        int k;
        k = 0;
        in_valid = 1'b1;
        x_in = DW'(x);
        y_in = DW'(y);
        in_last = last;
        while (!in_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("in_ready_wait", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        t = cyc;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_out(output int lat, input int t);
        int k;
        k = 0;
        while (!out_valid && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) chk("out_valid_wait", out_valid, 1);
        lat = cyc - t;
    endtask

    task automatic run_set(input int n, input int xs[8], input int ys[8], input bit ul,
                           output int r_s, output int r_i, output int r_d,
                           output bit r_sg, output bit r_st, output bit r_tr, output int lat);
        int t;
        t = 0;
        for (int i = 0; i < n; i++) send(xs[i], ys[i], ul && (i == n - 1), t);
        wait_out(lat, t);
        r_s = slope; r_i = intercept; r_d = det;
        r_sg = err_singular; r_st = err_sat; r_tr = err_trunc;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r_s, r_i, r_d, lat, t, e_s, e_i, e_d, rng, n;
        bit r_sg, r_st, r_tr, e_sg, e_st, e_tr, ul;
        int xs[8], ys[8];

        tbl[0] = '{3, 1'b1, 2, 1, 6, 1'b0, 1'b0, 1'b0};
        vx[0] = '{1, 2, 3, 0, 0, 0, 0, 0};      vy[0] = '{3, 5, 7, 0, 0, 0, 0, 0};
        tbl[1] = '{3, 1'b1, -3, 4, 6, 1'b0, 1'b0, 1'b0};
        vx[1] = '{0, 1, 2, 0, 0, 0, 0, 0};      vy[1] = '{4, 1, -2, 0, 0, 0, 0, 0};
        tbl[2] = '{2, 1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0};
        vx[2] = '{2, 2, 0, 0, 0, 0, 0, 0};      vy[2] = '{4, 5, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0};
        vx[3] = '{5, 0, 0, 0, 0, 0, 0, 0};      vy[3] = '{9, 0, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{3, 1'b1, SL4, 0, 6, 1'b0, 1'b0, 1'b0};
        vx[4] = '{0, 1, 2, 0, 0, 0, 0, 0};      vy[4] = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{2, 1'b1, 8191, -8192, 1, 1'b0, 1'b1, 1'b0};
        vx[5] = '{0, 1, 0, 0, 0, 0, 0, 0};      vy[5] = '{-8192, 8191, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{2, 1'b1, 0, 0, 8191, 1'b0, 1'b1, 1'b0};
        vx[6] = '{-8192, 8191, 0, 0, 0, 0, 0, 0}; vy[6] = '{0, 0, 0, 0, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_slope", slope, 0);
        chk("reset_intercept", intercept, 0);
        chk("reset_det", det, 0);
        chk("reset_errs", {err_singular, err_sat, err_trunc}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            run_set(tbl[v].n, vx[v], vy[v], tbl[v].use_last, r_s, r_i, r_d, r_sg, r_st, r_tr, lat);
            chk($sformatf("vec%0d_slope", v), r_s, tbl[v].slope);
            chk($sformatf("vec%0d_intercept", v), r_i, tbl[v].icpt);
            chk($sformatf("vec%0d_det", v), r_d, tbl[v].det);
            chk($sformatf("vec%0d_err_singular", v), r_sg, tbl[v].sing);
            chk($sformatf("vec%0d_err_sat", v), r_st, tbl[v].sat);
            chk($sformatf("vec%0d_err_trunc", v), r_tr, tbl[v].trunc);
            chk($sformatf("vec%0d_latency", v), lat, tbl[v].sing ? 2 : LAT);
            @(negedge clk);
            chk($sformatf("vec%0d_ready_after", v), in_ready, 1);
        end

        // Forced completion at MAX_SAMPLES, then a stalled consumer.
        t = 0;
        for (int i = 0; i < MS; i++) send(i + 1, i + 1, 1'b0, t);
        chk("trunc_busy", busy, 1);
        wait_out(lat, t);
        chk("trunc_latency", lat, LAT);
        for (int k = 0; k < 5; k++) begin
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_slope", slope, 1);
            chk("hold_intercept", intercept, 0);
            chk("hold_det", det, 336);
            chk("hold_err_trunc", err_trunc, 1);
            chk("hold_err_singular", err_singular, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("trunc_released_out_valid", out_valid, 0);
        chk("trunc_released_in_ready", in_ready, 1);
        chk("trunc_released_err_trunc", err_trunc, 0);

        // Reset in the middle of the slope division.
        for (int i = 0; i < 3; i++) send(vx[0][i], vy[0][i], i == 2, t);
        repeat (10) @(negedge clk);
        chk("mid_div_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        run_set(3, vx[0], vy[0], 1'b1, r_s, r_i, r_d, r_sg, r_st, r_tr, lat);
        chk("after_abort_slope", r_s, 2);
        chk("after_abort_intercept", r_i, 1);
        chk("after_abort_det", r_d, 6);
        chk("after_abort_latency", lat, LAT);
        @(negedge clk);

        for (int it = 0; it < 25; it++) begin
            n   = $urandom_range(1, MS);
            rng = ($urandom_range(0, 3) == 0) ? 8191 : 40;
            for (int i = 0; i < 8; i++) begin
                xs[i] = int'($urandom_range(0, 2 * rng)) - rng;
                ys[i] = int'($urandom_range(0, 2 * rng)) - rng;
            end
            ul = (n == MS) ? 1'($urandom_range(0, 1)) : 1'b1;
            model(n, xs, ys, ul, e_s, e_i, e_d, e_sg, e_st, e_tr);
            run_set(n, xs, ys, ul, r_s, r_i, r_d, r_sg, r_st, r_tr, lat);
            chk($sformatf("rnd%0d_slope", it), r_s, e_s);
            chk($sformatf("rnd%0d_intercept", it), r_i, e_i);
            chk($sformatf("rnd%0d_det", it), r_d, e_d);
            chk($sformatf("rnd%0d_err_singular", it), r_sg, e_sg);
            chk($sformatf("rnd%0d_err_sat", it), r_st, e_st);
            chk($sformatf("rnd%0d_err_trunc", it), r_tr, e_tr);
            chk($sformatf("rnd%0d_latency", it), lat, e_sg ? 2 : LAT);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
